// File: rtl/sig_capture.sv
// Triggered sample-capture buffer: arms, waits for an upward crossing of trig_level_i, records a window.
// Define SIGCAP_PRETRIG_EN to keep D/2 pre-trigger samples alongside D/2 post-trigger samples.
module sig_capture #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     arm_i,
  input  logic [DATA_WIDTH-1:0]    din_i,
  input  logic [DATA_WIDTH-1:0]    trig_level_i,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]    dout_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
  localparam int unsigned CNT_W = ADDRESS_WIDTH + 1;
`ifdef SIGCAP_PRETRIG_EN
  localparam int unsigned HALF = DEPTH / 2;
  localparam logic [CNT_W-1:0] REC_LEN = CNT_W'(HALF);
`else
  localparam logic [CNT_W-1:0] REC_LEN = CNT_W'(DEPTH);
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDRESS_WIDTH-1:0] start_addr_q, start_addr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0]    prev_q, prev_d;
  logic                     prev_valid_q, prev_valid_d;
  logic [DATA_WIDTH-1:0]    dout_q, dout_d;
  logic                     we_c;
  logic                     trig_c;
  logic [ADDRESS_WIDTH-1:0] rd_idx_c;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Upward crossing; the first sample after arming has no valid predecessor.
  always_comb begin
    trig_c = en_i && (state_q == S_ARMED) && prev_valid_q &&
             (prev_q < trig_level_i) && (din_i >= trig_level_i);
`ifdef SIGCAP_PRETRIG_EN
    trig_c = trig_c && (count_q >= CNT_W'(HALF));
`endif
  end

  assign rd_idx_c = start_addr_q + rd_addr_i;

  // Next-state and datapath control
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    start_addr_d = start_addr_q;
    count_d      = count_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    we_c         = 1'b0;
    dout_d       = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm_i) begin
          state_d      = S_ARMED;
          wr_addr_d    = '0;
          count_d      = '0;
          prev_valid_d = 1'b0;
        end
      end

      S_ARMED: begin
        if (en_i) begin
          prev_d       = din_i;
          prev_valid_d = 1'b1;
          if (trig_c) begin
            we_c      = 1'b1;
            wr_addr_d = wr_addr_q + ADDRESS_WIDTH'(1);
            count_d   = CNT_W'(1);
            state_d   = (REC_LEN == CNT_W'(1)) ? S_DONE : S_CAPTURE;
`ifdef SIGCAP_PRETRIG_EN
            start_addr_d = wr_addr_q - ADDRESS_WIDTH'(HALF);
`endif
          end else begin
`ifdef SIGCAP_PRETRIG_EN
            // Circular pre-trigger history; count only needs to reach D/2.
            we_c      = 1'b1;
            wr_addr_d = wr_addr_q + ADDRESS_WIDTH'(1);
            if (count_q < CNT_W'(HALF)) begin
              count_d = count_q + CNT_W'(1);
            end
`endif
          end
        end
      end

      S_CAPTURE: begin
        if (en_i) begin
          prev_d       = din_i;
          prev_valid_d = 1'b1;
          we_c         = 1'b1;
          wr_addr_d    = wr_addr_q + ADDRESS_WIDTH'(1);
          count_d      = count_q + CNT_W'(1);
          if (count_d == REC_LEN) begin
            state_d = S_DONE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Readout only while DONE is both current and next, so dout is 0 on entry and exit.
    if ((state_q == S_DONE) && (state_d == S_DONE)) begin
      dout_d = mem[rd_idx_c];
    end
  end

  // State and control registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      wr_addr_q    <= '0;
      start_addr_q <= '0;
      count_q      <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      start_addr_q <= start_addr_d;
      count_q      <= count_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      dout_q       <= dout_d;
    end
  end

  // Sample RAM, contents deliberately not reset
  always_ff @(posedge clk_i) begin
    if (we_c) begin
      mem[wr_addr_q] <= din_i;
    end
  end

  assign busy_o = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done_o = (state_q == S_DONE);
  assign dout_o = dout_q;

endmodule
